// File: rtl/lifo_pop_streamer.sv
// Pops up to burst_len words from a registered-read LIFO and streams them most-recent-first
// through a 2-entry skid buffer. Define LIFO_POP_PARITY_EN to add the m_parity output.
module lifo_pop_streamer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  output logic              lifo_rd,
  input  logic              lifo_empty,
  input  logic [DATA_W-1:0] lifo_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic              underrun,
  output logic [LEN_W-1:0]  word_count
`ifdef LIFO_POP_PARITY_EN
  ,
  output logic              m_parity
`endif
);

  typedef enum logic [1:0] {StIdle, StPop, StDrain, StDone} state_e;

  state_e             state_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   issued_q;
  logic [LEN_W-1:0]   recv_q;
  logic               inflight_q;

  // Skid buffer: entry 0 is the head, entry 1 only valid while entry 0 is.
  logic [DATA_W-1:0]  b0_q, b1_q;
  logic               l0_q, l1_q;
  logic               v0_q, v1_q;

  logic               xfer;
  logic               cap;
  logic               cap_last;
  logic               issue;
  logic               drain_empty;
  logic               ld0_new, ld0_shift, ld1_new;
  logic [1:0]         occ, occ_free, occ_next;

  always_comb begin
    xfer     = v0_q & m_ready;
    cap      = inflight_q;
    occ      = {1'b0, v0_q} + {1'b0, v1_q};
    occ_free = occ - {1'b0, xfer};
    occ_next = occ_free + {1'b0, cap};
    // The head leaving this cycle frees its slot, which is what allows one pop per cycle.
    issue    = !rst && (state_q == StPop) && (issued_q != len_q) && !lifo_empty &&
               ((occ_free + {1'b0, inflight_q}) < 2'd2);
    drain_empty = (occ_next == 2'd0) && !issue;
    cap_last    = ((recv_q + LEN_W'(1)) == len_q);
    ld0_new     = cap & (xfer ? ~v1_q : ~v0_q);
    ld0_shift   = xfer & v1_q;
    ld1_new     = cap & (xfer ? v1_q : v0_q);
  end

  // Pop strobe is decoded in the same cycle lifo_empty is seen, so the LIFO pointer and the
  // flag observed next cycle always agree with what has been issued.
  assign lifo_rd = issue;
  assign m_valid = v0_q;
  assign m_data  = b0_q;
  assign m_last  = l0_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      issued_q   <= '0;
      recv_q     <= '0;
      inflight_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
      word_count <= '0;
    end else begin
      done       <= 1'b0;
      inflight_q <= issue;
      if (issue) begin
        issued_q <= issued_q + LEN_W'(1);
      end
      if (cap) begin
        recv_q <= recv_q + LEN_W'(1);
      end
      if (xfer && (word_count != len_q)) begin
        word_count <= word_count + LEN_W'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            len_q      <= burst_len;
            issued_q   <= '0;
            recv_q     <= '0;
            word_count <= '0;
            underrun   <= 1'b0;
            if (burst_len == '0) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else begin
              state_q <= StPop;
              busy    <= 1'b1;
            end
          end
        end
        StPop: begin
          if ((issued_q == len_q) || (lifo_empty && !inflight_q)) begin
            if (issued_q != len_q) begin
              underrun <= 1'b1;
            end
            if (drain_empty) begin
              state_q <= StDone;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (drain_empty) begin
            state_q <= StDone;
            done    <= 1'b1;
            busy    <= 1'b0;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b0_q <= '0;
      b1_q <= '0;
      l0_q <= 1'b0;
      l1_q <= 1'b0;
      v0_q <= 1'b0;
      v1_q <= 1'b0;
    end else begin
      v0_q <= (occ_next != 2'd0);
      v1_q <= (occ_next == 2'd2);
      if (ld0_new) begin
        b0_q <= lifo_data;
        l0_q <= cap_last;
      end else if (ld0_shift) begin
        b0_q <= b1_q;
        l0_q <= l1_q;
      end else if (xfer) begin
        l0_q <= 1'b0;
      end
      if (ld1_new) begin
        b1_q <= lifo_data;
        l1_q <= cap_last;
      end
    end
  end

`ifdef LIFO_POP_PARITY_EN
  logic p0_q, p1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      p0_q <= 1'b0;
      p1_q <= 1'b0;
    end else begin
      if (ld0_new) begin
        p0_q <= ^lifo_data;
      end else if (ld0_shift) begin
        p0_q <= p1_q;
      end
      if (ld1_new) begin
        p1_q <= ^lifo_data;
      end
    end
  end

  assign m_parity = p0_q;
`endif

endmodule

// File: tb/tb_lifo_pop_streamer.sv
// Directed bench for lifo_pop_streamer: a LIFO model feeds the DUT while a queue-based
// model checks every streamed word, stall behaviour, pop budget and the completion report.
module tb_lifo_pop_streamer;
  localparam int DW = 32;
  localparam int LW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic          lifo_rd;
  logic          lifo_empty;
  logic [DW-1:0] lifo_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;
  logic          underrun;
  logic [LW-1:0] word_count;
`ifdef LIFO_POP_PARITY_EN
  logic          m_parity;
`endif

  lifo_pop_streamer #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .burst_len  (burst_len),
    .lifo_rd    (lifo_rd),
    .lifo_empty (lifo_empty),
    .lifo_data  (lifo_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun),
    .word_count (word_count)
`ifdef LIFO_POP_PARITY_EN
    ,
    .m_parity   (m_parity)
`endif
  );

  always #5 clk = ~clk;

  // LIFO environment: registered read, pointer moves on the pop edge.
  logic [DW-1:0] lmem [0:511];
  int            lptr = 0;
  logic          lclr = 1'b0;
  logic          lwr = 1'b0;
  logic [DW-1:0] lwdata = '0;
  assign lifo_empty = (lptr == 0);

  always @(posedge clk) begin
    if (lclr) lptr <= 0;
    else if (lwr) begin
      lmem[lptr] <= lwdata;
      lptr <= lptr + 1;
    end else if (lifo_rd && lptr != 0) begin
      lifo_data <= lmem[lptr-1];
      lptr <= lptr - 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Model state describing the burst in progress.
  logic [DW-1:0] exp_q[$];
  int            exp_len = 0;
  int            exp_cnt = 0;
  bit            exp_under = 1'b0;
  int            n_xfer = 0;
  int            last_xfer_cyc = 0;
  logic [DW-1:0] got_log[$];
  bit            last_log[$];
  bit            par_log[$];
  int            xcyc_log[$];
  int            done_cnt = 0;
  int            rd_total = 0;

  initial begin : compare
    int outstanding;
    bit prev_hold;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] e;
    outstanding = 0;
    prev_hold = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        outstanding = 0;
        prev_hold = 1'b0;
      end else begin
        if (lifo_rd) begin
          rd_total++;
          check("rd_on_empty", lifo_empty, 1'b0);
          check("rd_over_capacity", (outstanding + 1 - int'(m_valid && m_ready)) <= 2, 1'b1);
        end
        if (prev_hold) begin
          check("stall_valid_held", m_valid, 1'b1);
          check("stall_data_held", m_data, prev_data);
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", m_data, 32'hdead_beef);
          end else begin
            e = exp_q.pop_front();
            n_xfer++;
            check("stream_data", m_data, e);
            check("stream_last", m_last, (!exp_under && n_xfer == exp_len));
`ifdef LIFO_POP_PARITY_EN
            check("stream_parity", m_parity, ^e);
            par_log.push_back(m_parity);
`endif
          end
          got_log.push_back(m_data);
          last_log.push_back(m_last);
          xcyc_log.push_back(cyc);
          last_xfer_cyc = cyc;
        end
        outstanding += int'(lifo_rd && !lifo_empty) - int'(m_valid && m_ready);
        if (done) begin
          done_cnt++;
          check("done_word_count", word_count, exp_cnt);
          check("done_underrun", underrun, exp_under);
          check("done_all_delivered", exp_q.size(), 0);
          check("done_busy_low", busy, 1'b0);
          if (exp_cnt > 0 && !exp_under) check("done_after_last", cyc, last_xfer_cyc + 1);
        end
        prev_hold = m_valid && !m_ready;
        prev_data = m_data;
      end
    end
  end

  logic [DW-1:0] wl[$];

  task automatic load_lifo(input bit clr);
    if (clr) begin
      lclr = 1'b1;
      @(posedge clk); #1;
      lclr = 1'b0;
    end
    foreach (wl[i]) begin
      lwdata = wl[i];
      lwr = 1'b1;
      @(posedge clk); #1;
    end
    lwr = 1'b0;
  endtask

  task automatic start_burst(input int len);
    int n;
    n = (len < lptr) ? len : lptr;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(lmem[lptr-1-i]);
    exp_len = len;
    exp_cnt = n;
    exp_under = (len > lptr);
    n_xfer = 0;
    got_log.delete();
    last_log.delete();
    par_log.delete();
    xcyc_log.delete();
    start = 1'b1;
    burst_len = LW'(len);
    @(posedge clk); #1;
    start = 1'b0;
    burst_len = '1;
  endtask

  task automatic wait_done(input int max, output int waited);
    waited = -1;
    for (int k = 1; k <= max; k++) begin
      @(negedge clk);
      if (done) begin
        waited = k;
        break;
      end
    end
    if (waited < 0) check("done_timeout", 0, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int w;
    int snap;
    logic [6:0] rdy_pat;
    rdy_pat = 7'b1101001;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_lifo_rd", lifo_rd, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 32'h0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_word_count", word_count, 0);
`ifdef LIFO_POP_PARITY_EN
    check("rst_m_parity", m_parity, 1'b0);
`endif
    @(posedge clk); #1;

    // Full-rate burst of 3 out of 4.
    wl = {32'h11, 32'h22, 32'h33, 32'h44};
    load_lifo(1'b1);
    start_burst(3);
    check("t1_busy", busy, 1'b1);
    wait_done(40, w);
    check("t1_done_latency", w, 6);
    check("t1_nwords", got_log.size(), 3);
    check("t1_w0", got_log[0], 32'h44);
    check("t1_w1", got_log[1], 32'h33);
    check("t1_w2", got_log[2], 32'h22);
    check("t1_last_pos", {last_log[0], last_log[1], last_log[2]}, 3'b001);
    check("t1_consecutive", xcyc_log[2] - xcyc_log[0], 2);
    check("t1_word_count", word_count, 3);
    check("t1_underrun", underrun, 1'b0);
    check("t1_lifo_left", lptr, 1);
    @(posedge clk); #1;

    // Underrun: two words available, five requested.
    wl = {32'h55};
    load_lifo(1'b0);
    start_burst(5);
    wait_done(40, w);
    check("t2_nwords", got_log.size(), 2);
    check("t2_w0", got_log[0], 32'h55);
    check("t2_w1", got_log[1], 32'h11);
    check("t2_no_last", {last_log[0], last_log[1]}, 2'b00);
    check("t2_underrun", underrun, 1'b1);
    check("t2_word_count", word_count, 2);
    check("t2_lifo_empty", lifo_empty, 1'b1);
    repeat (2) @(negedge clk);
    check("t2_underrun_held", underrun, 1'b1);
    @(posedge clk); #1;

    // Back-pressure with a start pulse while busy that must be ignored.
    wl = {32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5};
    load_lifo(1'b1);
    start_burst(4);
    for (int i = 0; i < 7; i++) begin
      m_ready = rdy_pat[i];
      start = (i == 2);
      burst_len = (i == 2) ? LW'(1) : '1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    m_ready = 1'b1;
    wait_done(60, w);
    check("t3_nwords", got_log.size(), 4);
    check("t3_w0", got_log[0], 32'hA5);
    check("t3_w3", got_log[3], 32'hA2);
    check("t3_last_pos", {last_log[0], last_log[1], last_log[2], last_log[3]}, 4'b0001);
    check("t3_lifo_left", lptr, 2);
    @(posedge clk); #1;

    // Zero-length burst.
    snap = rd_total;
    start_burst(0);
    wait_done(10, w);
    check("t4_done_latency", w, 1);
    check("t4_word_count", word_count, 0);
    check("t4_underrun", underrun, 1'b0);
    @(negedge clk);
    check("t4_no_rd", rd_total, snap);
    @(posedge clk); #1;

    // Reset the cycle after the first pop, then fetch the new top.
    wl = {32'hB1, 32'hB2, 32'hB3, 32'hB4};
    load_lifo(1'b1);
    start_burst(4);
    @(negedge clk);
    check("t5_rd_issued", lifo_rd, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    snap = done_cnt;
    @(negedge clk);
    check("t5_rst_lifo_rd", lifo_rd, 1'b0);
    check("t5_rst_m_valid", m_valid, 1'b0);
    check("t5_rst_m_data", m_data, 32'h0);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_done", done, 1'b0);
    check("t5_rst_word_count", word_count, 0);
    repeat (5) @(negedge clk);
    check("t5_no_done", done_cnt, snap);
    @(posedge clk); #1;
    start_burst(1);
    wait_done(20, w);
    check("t5_top_word", got_log[0], 32'hB3);
    check("t5_last", last_log[0], 1'b1);
    @(posedge clk); #1;

`ifdef LIFO_POP_PARITY_EN
    wl = {32'h3, 32'h7};
    load_lifo(1'b1);
    start_burst(2);
    wait_done(20, w);
    check("par_0x7", par_log[0], 1'b1);
    check("par_0x3", par_log[1], 1'b0);
    @(posedge clk); #1;
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
